instr_prefetch: RTL and testbench

INSTR_PREFETCH -- requirements
Module: instr_prefetch

---
 rtl/instr_prefetch.sv | 189 ++++++++++++++++++
 tb/tb_instr_prefetch.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch.sv
// instr_prefetch: burst instruction prefetcher feeding a first-word-fall-through buffer.
// Define INSTR_PREFETCH_ZERO_HALT_EN to stop fetching after an all-zero beat.
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'h0
`endif

module instr_prefetch #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BURST_BEATS    = 8,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [63:0]               entry,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack,
  input  logic                      redirect_valid,
  input  logic [63:0]               redirect_pc,
  output logic                      instr_valid,
  input  logic                      instr_ready,
  output logic [31:0]               instr,
  output logic [63:0]               instr_pc,
  output logic                      halt
);

  localparam logic [63:0] BURST_BYTES = 64'(BURST_BEATS * 8);
  localparam logic [63:0] ALIGN_MASK = ~(BURST_BYTES - 64'd1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(BURST_BEATS) + 1;
  localparam logic [CW-1:0] LAST = CW'(BURST_BEATS - 1);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [BUS_TAG_WIDTH-1:0] TAG =
    BUS_TAG_WIDTH'({1'b1, `SYSBUS_MEMORY, 8'b0});

  typedef enum logic [2:0] {IDLE, REQ, RESP, DRAIN, HALT} state_t;

  state_t state, state_n;
  logic [63:0] fetch, fetch_n;
  logic [63:0] target, target_n;
  logic [CW-1:0] cnt, cnt_n;
  logic halt_pend, halt_pend_n;

  logic [31:0] mem_i [FIFO_DEPTH];
  logic [63:0] mem_pc [FIFO_DEPTH];
  logic [AW-1:0] rd, wr;
  logic [AW:0] count;

  logic redir, fire, last, zero, push, pop;
  logic keep_lo, keep_hi;
  logic [63:0] beat_addr;
  logic [1:0] n_push;
  logic unused_tag;

  assign unused_tag = ^bus_resptag;

  assign redir = redirect_valid && (state != IDLE);
  assign fire = bus_respcyc && bus_respack;
  assign last = (cnt == LAST);
  assign beat_addr = fetch + (64'(cnt) << 3);
  assign keep_lo = (beat_addr >= target);
  assign keep_hi = ((beat_addr + 64'd4) >= target);

`ifdef INSTR_PREFETCH_ZERO_HALT_EN
  assign zero = (bus_resp == '0);
  assign halt = (state == HALT);
`else
  assign zero = 1'b0;
  assign halt = 1'b0;
`endif

  assign push = (state == RESP) && fire && !redir && !zero;
  assign n_push = push ? ({1'b0, keep_lo} + {1'b0, keep_hi}) : 2'd0;

  assign instr_valid = (count != '0);
  assign pop = instr_valid && instr_ready && !redir;
  assign instr = mem_i[rd];
  assign instr_pc = mem_pc[rd];

  assign bus_reqcyc = (state == REQ);
  assign bus_req = bus_reqcyc ? fetch : '0;
  assign bus_reqtag = bus_reqcyc ? TAG : '0;

  // Free space counts registered occupancy only, keeping instr_ready off the bus path
  always_comb begin
    bus_respack = 1'b0;
    if (!reset) begin
      if (state == RESP)
        bus_respack = bus_respcyc && ((DEPTH - count) >= (AW+1)'(2));
      else if (state == DRAIN)
        bus_respack = bus_respcyc;
    end
  end

  always_comb begin
    state_n = state;
    fetch_n = fetch;
    target_n = target;
    cnt_n = cnt;
    halt_pend_n = halt_pend;
    if (fire)
      cnt_n = last ? '0 : cnt + 1'b1;
    if (redir) begin
      fetch_n = redirect_pc & ALIGN_MASK;
      target_n = redirect_pc;
      halt_pend_n = 1'b0;
    end
    unique case (state)
      IDLE: state_n = REQ;
      REQ: begin
        cnt_n = '0;
        if (redir)
          state_n = bus_reqack ? DRAIN : REQ;
        else if (bus_reqack)
          state_n = RESP;
      end
      RESP: begin
        if (redir) begin
          state_n = (fire && last) ? REQ : DRAIN;
        end else if (fire && zero) begin
          state_n = last ? HALT : DRAIN;
          halt_pend_n = !last;
        end else if (fire && last) begin
          fetch_n = fetch + BURST_BYTES;
          target_n = fetch + BURST_BYTES;
          state_n = REQ;
        end
      end
      DRAIN: begin
        if (fire && last) begin
          state_n = halt_pend_n ? HALT : REQ;
          halt_pend_n = 1'b0;
        end
      end
      HALT: if (redir) state_n = REQ;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      fetch <= entry & ALIGN_MASK;
      target <= entry;
      cnt <= '0;
      halt_pend <= 1'b0;
    end else begin
      state <= state_n;
      fetch <= fetch_n;
      target <= target_n;
      cnt <= cnt_n;
      halt_pend <= halt_pend_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || redir) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      wr <= wr + AW'(n_push);
      rd <= rd + AW'(pop);
      count <= count + (AW+1)'(n_push) - (AW+1)'(pop);
    end
  end

  // Leading words below the target PC are dropped before they reach the buffer
  always_ff @(posedge clk) begin
    if (push) begin
      if (keep_lo) begin
        mem_i[wr] <= bus_resp[31:0];
        mem_pc[wr] <= beat_addr;
        mem_i[wr + AW'(1)] <= bus_resp[63:32];
        mem_pc[wr + AW'(1)] <= beat_addr + 64'd4;
      end else if (keep_hi) begin
        mem_i[wr] <= bus_resp[63:32];
        mem_pc[wr] <= beat_addr + 64'd4;
      end
    end
  end

endmodule

// File: tb/tb_instr_prefetch.sv
// tb_instr_prefetch: random bus slave plus scoreboard of the sequential instruction stream.
// Covers reset, stall, redirect, zero beat and mid-burst reset scenarios.
module tb_instr_prefetch;

  localparam int BB = 8;
  localparam int WIN = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [63:0] entry;
  logic        bus_reqcyc;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_reqack;
  logic        bus_respcyc;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic        bus_respack;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        halt;

  instr_prefetch dut (
    .clk(clk), .reset(reset), .entry(entry),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
    .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
    .bus_resptag(bus_resptag), .bus_respack(bus_respack),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .halt(halt)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] w;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  int delivered = 0;
  int beats_left = 0;
  int beats_done = 0;
  int fires = 0;
  bit zero_on = 1'b0;
  logic [63:0] zero_addr = '0;
  logic [63:0] exp_fetch = '0;
  logic [63:0] cur = '0;

  // Memory image seen by the bus; a few fixed words plus an optional all-zero beat
  function automatic logic [31:0] word(input logic [63:0] a);
    if (zero_on && (a[63:3] == zero_addr[63:3])) return 32'h0;
    if (a == 64'h1000) return 32'h00100013;
    if (a == 64'h1004) return 32'h00500093;
    return ((a[31:0] * 32'h9E3779B1) ^ 32'h0BADF00D) | 32'h1;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // After a (re)start at p the consumer must see p, p+4, p+8 ...
  task automatic push_window(input logic [63:0] p);
    logic [63:0] a;
    exp_q.delete();
    for (int i = 0; i < WIN; i++) begin
      a = p + 64'(4 * i);
`ifdef INSTR_PREFETCH_ZERO_HALT_EN
      if (zero_on && a >= zero_addr) break;
`endif
      exp_q.push_back('{a, word(a)});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_reset(input logic [63:0] e);
    reset = 1'b1;
    entry = e;
    redirect_valid = 1'b0;
    exp_fetch = e & ~64'h3F;
    push_window(e);
  endtask

  task automatic wait_deliver(input int n, input int budget);
    int start;
    int c;
    start = delivered;
    c = 0;
    while (delivered < start + n && c < budget) begin
      tick();
      c++;
    end
    check("deliver_progress", 64'(delivered >= start + n), 64'd1);
  endtask

  // Bus slave: one burst in flight, random accept and beat gaps
  initial begin
    bit rf, bf;
    bus_reqack = 1'b0;
    bus_respcyc = 1'b0;
    bus_resp = '0;
    bus_resptag = '0;
    forever begin
      @(negedge clk);
      rf = bus_reqcyc && bus_reqack;
      bf = bus_respcyc && bus_respack;
      if (reset) begin
        beats_left = 0;
      end else begin
        if (bf) begin
          beats_left--;
          beats_done++;
          fires++;
          cur = cur + 64'd8;
        end
        if (rf) begin
          check("burst_complete", 64'(beats_left), 64'd0);
          check("reqtag", 64'({bus_reqtag[12], bus_reqtag[7:0]}), 64'h100);
          if (!redirect_valid) begin
            check("bus_req", bus_req, exp_fetch);
            exp_fetch = exp_fetch + 64'(BB * 8);
          end
          beats_left = BB;
          beats_done = 0;
          cur = bus_req;
        end
      end
      @(posedge clk);
      #1;
      bus_reqack = ($urandom % 4) != 0;
      if (beats_left > 0 && ($urandom % 4) != 0) begin
        bus_respcyc = 1'b1;
        bus_resp = {word(cur + 64'd4), word(cur)};
      end else begin
        bus_respcyc = 1'b0;
        bus_resp = '0;
      end
    end
  end

  // Monitor: every accepted instruction is popped against the expected stream
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && !redirect_valid && instr_valid && instr_ready) begin
        delivered++;
        if (exp_q.size() == 0) begin
          check("unexpected_instr_pc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("instr_pc", instr_pc, e.pc);
          check("instr", 64'(instr), 64'(e.w));
        end
      end
    end
  end

  initial begin
    #1000000;
    bad++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int seen;
    int d0;
    int since;
    logic [63:0] pc;
    reset = 1'b1;
    entry = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;

    // Reset values and the basic 0x1000 fetch
    tick();
    start_reset(64'h1000);
    instr_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_reqcyc", 64'(bus_reqcyc), 64'd0);
    check("rst_respack", 64'(bus_respack), 64'd0);
    check("rst_req", bus_req, 64'd0);
    check("rst_reqtag", 64'(bus_reqtag), 64'd0);
    check("rst_instr_valid", 64'(instr_valid), 64'd0);
    check("rst_halt", 64'(halt), 64'd0);
    tick();
    reset = 1'b0;
    wait_deliver(20, 300);

    // Redirect while the third beat of a burst is presented
    c = 0;
    while (!(beats_left > 0 && beats_done == 2) && c < 300) begin
      tick();
      c++;
    end
    check("wait_beat2", 64'(c < 300), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc = 64'h2014;
    push_window(64'h2014);
    exp_fetch = 64'h2000;
    tick();
    redirect_valid = 1'b0;
    wait_deliver(12, 300);

    // Consumer stalled: buffer fills to 16 and beats stop being taken
    tick();
    start_reset(64'h3000);
    instr_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    fires = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i >= 25 && bus_respack) seen++;
      tick();
    end
    check("stall_beats", 64'(fires), 64'd8);
    check("stall_respack", 64'(seen), 64'd0);
    instr_ready = 1'b1;
    wait_deliver(40, 400);

    // All-zero beat at base+0x18
    tick();
    zero_on = 1'b1;
    zero_addr = 64'h4018;
    start_reset(64'h4000);
    repeat (2) tick();
    reset = 1'b0;
    d0 = delivered;
    repeat (150) tick();
    @(negedge clk);
`ifdef INSTR_PREFETCH_ZERO_HALT_EN
    check("zero_count", 64'(delivered - d0), 64'd6);
    check("zero_halt", 64'(halt), 64'd1);
    check("zero_reqcyc", 64'(bus_reqcyc), 64'd0);
`else
    check("zero_halt", 64'(halt), 64'd0);
    check("zero_progress", 64'(delivered - d0 >= 16), 64'd1);
`endif

    // Reset during the fifth beat of a burst
    tick();
    zero_on = 1'b0;
    start_reset(64'h6000);
    repeat (2) tick();
    reset = 1'b0;
    c = 0;
    while (!(beats_left > 0 && beats_done == 4) && c < 300) begin
      tick();
      c++;
    end
    check("wait_beat4", 64'(c < 300), 64'd1);
    start_reset(64'h5000);
    tick();
    @(negedge clk);
    check("mid_rst_reqcyc", 64'(bus_reqcyc), 64'd0);
    check("mid_rst_respack", 64'(bus_respack), 64'd0);
    check("mid_rst_valid", 64'(instr_valid), 64'd0);
    tick();
    reset = 1'b0;
    wait_deliver(10, 300);

    // Random consumer and redirect traffic
    d0 = delivered;
    since = 0;
    for (int i = 0; i < 1500; i++) begin
      tick();
      instr_ready = ($urandom % 4) != 0;
      redirect_valid = 1'b0;
      if (since > 8 && ($urandom % 60) == 0) begin
        pc = 64'($urandom_range(0, 32'hFFFF)) & ~64'h3;
        redirect_valid = 1'b1;
        redirect_pc = pc;
        push_window(pc);
        exp_fetch = pc & ~64'h3F;
        since = 0;
      end else begin
        since++;
      end
    end
    tick();
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    repeat (50) tick();
    check("random_progress", 64'(delivered - d0 > 200), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
